// File: rtl/frame_pkg.sv
// Shared definitions for the raster-to-window coordinate mapper.
// Default widths, the power-up window and the window config layout.
package frame_pkg;

  localparam int COORD_W = 10;
  localparam int SCALE_W = 2;

  localparam int DEF_X0 = 185;
  localparam int DEF_Y0 = 30;
  localparam int DEF_W  = 640;
  localparam int DEF_H  = 480;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [SCALE_W-1:0] scale;
  } win_cfg_t;

endpackage

// File: rtl/window_hit.sv
// Stage-1 containment test and origin subtraction for one window.
// Edge sums carry one extra bit so x0+w past the raster range still works.
module window_hit #(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic               hit,
  output logic [COORD_W-1:0] dx,
  output logic [COORD_W-1:0] dy
);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;
  logic             in_x;
  logic             in_y;

  assign x_end = {1'b0, x0} + {1'b0, w};
  assign y_end = {1'b0, y0} + {1'b0, h};
  assign in_x  = (x >= x0) && ({1'b0, x} < x_end);
  assign in_y  = (y >= y0) && ({1'b0, y} < y_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit <= 1'b0;
      dx  <= '0;
      dy  <= '0;
    end else begin
      hit <= en & valid & in_x & in_y;
      dx  <= x - x0;
      dy  <= y - y0;
    end
  end

endmodule

// File: rtl/frame_window_mapper.sv
// Maps raster coordinates onto up to NUM_WIN prioritised frame windows.
// Double-buffered config commits at the frame origin; fixed 2-cycle latency.
module frame_window_mapper #(
  parameter int COORD_W = frame_pkg::COORD_W,
  parameter int NUM_WIN = 2,
  parameter int IDX_W   = 3,
  parameter int SCALE_W = frame_pkg::SCALE_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] vga_x_in,
  input  logic [COORD_W-1:0] vga_y_in,
  input  logic               pix_valid_in,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [COORD_W-1:0] cfg_x0,
  input  logic [COORD_W-1:0] cfg_y0,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  input  logic [SCALE_W-1:0] cfg_scale,
  output logic [COORD_W-1:0] frame_x,
  output logic [COORD_W-1:0] frame_y,
  output logic [IDX_W-1:0]   frame_idx,
  output logic               frame_there,
  output logic               frame_start
);

  import frame_pkg::*;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [SCALE_W-1:0] scale;
  } cfg_t;

  function automatic cfg_t reset_cfg(int i);
    cfg_t c;
    c = '0;
    if (i == 0) begin
      c.en = 1'b1;
      c.x0 = COORD_W'(DEF_X0);
      c.y0 = COORD_W'(DEF_Y0);
      c.w  = COORD_W'(DEF_W);
      c.h  = COORD_W'(DEF_H);
    end
    return c;
  endfunction

  cfg_t shadow [NUM_WIN];
  cfg_t active [NUM_WIN];
  logic commit;

  assign commit = pix_valid_in
                & (vga_x_in == '0)
                & (vga_y_in == '0);

  // Writes to indices outside the bank match no entry and are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        shadow[i] <= reset_cfg(i);
        active[i] <= reset_cfg(i);
      end
    end else begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          shadow[i] <= {cfg_en, cfg_x0, cfg_y0,
                        cfg_w, cfg_h, cfg_scale};
        end
        if (commit) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  logic [NUM_WIN-1:0] s1_hit;
  logic [COORD_W-1:0] s1_dx    [NUM_WIN];
  logic [COORD_W-1:0] s1_dy    [NUM_WIN];
  logic [SCALE_W-1:0] s1_scale [NUM_WIN];
  logic               s1_start;

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    window_hit #(
      .COORD_W (COORD_W)
    ) u_hit (
      .clk     (clk),
      .reset_n (reset_n),
      .valid   (pix_valid_in),
      .x       (vga_x_in),
      .y       (vga_y_in),
      .en      (active[g].en),
      .x0      (active[g].x0),
      .y0      (active[g].y0),
      .w       (active[g].w),
      .h       (active[g].h),
      .hit     (s1_hit[g]),
      .dx      (s1_dx[g]),
      .dy      (s1_dy[g])
    );
  end

  // Scale travels with the pixel so a commit cannot skew an in-flight one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_start <= 1'b0;
      for (int i = 0; i < NUM_WIN; i++) begin
        s1_scale[i] <= '0;
      end
    end else begin
      s1_start <= commit;
      for (int i = 0; i < NUM_WIN; i++) begin
        s1_scale[i] <= active[i].scale;
      end
    end
  end

  logic               sel_hit;
  logic [IDX_W-1:0]   sel_idx;
  logic [COORD_W-1:0] sel_dx;
  logic [COORD_W-1:0] sel_dy;
  logic [SCALE_W-1:0] sel_scale;

  always_comb begin
    sel_hit   = 1'b0;
    sel_idx   = '0;
    sel_dx    = '0;
    sel_dy    = '0;
    sel_scale = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        sel_hit   = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_dx    = s1_dx[i];
        sel_dy    = s1_dy[i];
        sel_scale = s1_scale[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_x     <= '0;
      frame_y     <= '0;
      frame_idx   <= '0;
      frame_there <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_there <= sel_hit;
      frame_start <= s1_start;
      if (sel_hit) begin
        frame_x   <= sel_dx >> sel_scale;
        frame_y   <= sel_dy >> sel_scale;
        frame_idx <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_frame_window_mapper.sv
// Directed bench for frame_window_mapper: defaults, priority, scaling,
// double buffering, edge cases and asynchronous reset.
module tb_frame_window_mapper;

  logic       clk;
  logic       reset_n;
  logic [9:0] vga_x_in;
  logic [9:0] vga_y_in;
  logic       pix_valid_in;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic       cfg_en;
  logic [9:0] cfg_x0;
  logic [9:0] cfg_y0;
  logic [9:0] cfg_w;
  logic [9:0] cfg_h;
  logic [1:0] cfg_scale;
  logic [9:0] frame_x;
  logic [9:0] frame_y;
  logic [2:0] frame_idx;
  logic       frame_there;
  logic       frame_start;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  frame_window_mapper #(
    .COORD_W (10),
    .NUM_WIN (2),
    .IDX_W   (3),
    .SCALE_W (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vga_x_in     (vga_x_in),
    .vga_y_in     (vga_y_in),
    .pix_valid_in (pix_valid_in),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_en       (cfg_en),
    .cfg_x0       (cfg_x0),
    .cfg_y0       (cfg_y0),
    .cfg_w        (cfg_w),
    .cfg_h        (cfg_h),
    .cfg_scale    (cfg_scale),
    .frame_x      (frame_x),
    .frame_y      (frame_y),
    .frame_idx    (frame_idx),
    .frame_there  (frame_there),
    .frame_start  (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input logic v);
    vga_x_in     = 10'(x);
    vga_y_in     = 10'(y);
    pix_valid_in = v;
  endtask

  // Apply one input, idle, then sample two cycles after it was applied.
  task automatic probe(input int x, input int y, input logic v);
    @(negedge clk);
    drive(x, y, v);
    @(negedge clk);
    drive(0, 0, 1'b0);
    @(negedge clk);
  endtask

  task automatic cfg_write(input int idx, input logic en,
                           input int x0, input int y0,
                           input int w, input int h, input int s);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_en    = en;
    cfg_x0    = 10'(x0);
    cfg_y0    = 10'(y0);
    cfg_w     = 10'(w);
    cfg_h     = 10'(h);
    cfg_scale = 2'(s);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic commit_chk(input string tag);
    @(negedge clk);
    drive(0, 0, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0);
    chk({tag, "_start_early"}, 32'(frame_start), 0);
    @(negedge clk);
    chk({tag, "_start"}, 32'(frame_start), 1);
  endtask

  int exp_ds [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 1'b0);
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_x0 = '0; cfg_y0 = '0; cfg_w = '0; cfg_h = '0;
    cfg_scale = '0;
    repeat (3) @(negedge clk);
    chk("rst_x", 32'(frame_x), 0);
    chk("rst_y", 32'(frame_y), 0);
    chk("rst_idx", 32'(frame_idx), 0);
    chk("rst_there", 32'(frame_there), 0);
    chk("rst_start", 32'(frame_start), 0);
    reset_n = 1'b1;

    probe(185, 30, 1'b1);
    chk("def_origin_there", 32'(frame_there), 1);
    chk("def_origin_x", 32'(frame_x), 0);
    chk("def_origin_y", 32'(frame_y), 0);
    chk("def_origin_idx", 32'(frame_idx), 0);
    probe(825, 30, 1'b1);
    chk("def_right_edge", 32'(frame_there), 0);
    probe(824, 509, 1'b1);
    chk("def_corner_there", 32'(frame_there), 1);
    chk("def_corner_x", 32'(frame_x), 639);
    chk("def_corner_y", 32'(frame_y), 479);

    cfg_write(1, 1'b1, 0, 0, 300, 300, 0);
    commit_chk("prio");
    probe(200, 40, 1'b1);
    chk("prio_w0_idx", 32'(frame_idx), 0);
    chk("prio_w0_x", 32'(frame_x), 15);
    chk("prio_w0_y", 32'(frame_y), 10);
    probe(100, 100, 1'b1);
    chk("prio_w1_there", 32'(frame_there), 1);
    chk("prio_w1_idx", 32'(frame_idx), 1);
    chk("prio_w1_x", 32'(frame_x), 100);
    chk("prio_w1_y", 32'(frame_y), 100);

    cfg_write(0, 1'b1, 185, 30, 640, 480, 2);
    cfg_write(1, 1'b0, 0, 0, 0, 0, 0);
    commit_chk("scale");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("ds_x", 32'(frame_x), 32'(exp_ds[c-2]));
        chk("ds_y", 32'(frame_y), 0);
        chk("ds_there", 32'(frame_there), 1);
      end
      if (c < 8) drive(185 + c, 30, 1'b1);
      else drive(0, 0, 1'b0);
    end

    probe(185, 30, 1'b1);
    chk("db_pre_x", 32'(frame_x), 0);
    cfg_write(0, 1'b1, 0, 30, 640, 480, 0);
    probe(100, 50, 1'b1);
    chk("db_old_there", 32'(frame_there), 0);
    chk("db_old_x", 32'(frame_x), 0);
    commit_chk("db");
    probe(100, 50, 1'b1);
    chk("db_new_there", 32'(frame_there), 1);
    chk("db_new_x", 32'(frame_x), 100);
    chk("db_new_y", 32'(frame_y), 20);

    probe(300, 100, 1'b0);
    chk("gate_there", 32'(frame_there), 0);
    chk("gate_hold_x", 32'(frame_x), 100);
    chk("gate_hold_y", 32'(frame_y), 20);

    cfg_write(1, 1'b1, 1000, 0, 100, 100, 0);
    commit_chk("ovf");
    probe(1023, 10, 1'b1);
    chk("ovf_there", 32'(frame_there), 1);
    chk("ovf_idx", 32'(frame_idx), 1);
    chk("ovf_x", 32'(frame_x), 23);
    chk("ovf_y", 32'(frame_y), 10);
    probe(999, 10, 1'b1);
    chk("ovf_left_miss", 32'(frame_there), 0);

    cfg_write(0, 1'b1, 0, 0, 0, 480, 0);
    commit_chk("w0");
    probe(5, 5, 1'b1);
    chk("w0_there", 32'(frame_there), 0);
    chk("w0_hold_x", 32'(frame_x), 23);

    @(negedge clk);
    drive(1010, 20, 1'b1);
    @(negedge clk);
    drive(1011, 20, 1'b1);
    @(negedge clk);
    chk("mid_there", 32'(frame_there), 1);
    chk("mid_idx", 32'(frame_idx), 1);
    chk("mid_x", 32'(frame_x), 10);
    #2;
    reset_n = 1'b0;
    drive(0, 0, 1'b0);
    #1;
    chk("arst_x", 32'(frame_x), 0);
    chk("arst_y", 32'(frame_y), 0);
    chk("arst_idx", 32'(frame_idx), 0);
    chk("arst_there", 32'(frame_there), 0);
    chk("arst_start", 32'(frame_start), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive(190, 37, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0);
    chk("post_rst_1cyc", 32'(frame_there), 0);
    @(negedge clk);
    chk("post_rst_there", 32'(frame_there), 1);
    chk("post_rst_idx", 32'(frame_idx), 0);
    chk("post_rst_x", 32'(frame_x), 5);
    chk("post_rst_y", 32'(frame_y), 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
